// File: rtl/alu_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared 6-bit ALU.
// master = requesters plus the ALU instance; slave = the arbiter.
interface alu_arbiter_if;
  logic       req0, req1;
  logic [5:0] x0, y0, x1, y1;
  logic [2:0] fxn0, fxn1;
  logic       ack0, ack1, done0, done1;
  logic [5:0] out;
  logic       carry, over, agteqb, busy;
  logic [5:0] alu_x, alu_y;
  logic [2:0] alu_fxn;
  logic [5:0] alu_out;
  logic       alu_carry, alu_over, alu_agteqb;

  modport master (
    output req0, req1, x0, y0, x1, y1, fxn0, fxn1,
    output alu_out, alu_carry, alu_over, alu_agteqb,
    input  ack0, ack1, done0, done1, out, carry, over, agteqb, busy,
    input  alu_x, alu_y, alu_fxn
  );

  modport slave (
    input  req0, req1, x0, y0, x1, y1, fxn0, fxn1,
    input  alu_out, alu_carry, alu_over, alu_agteqb,
    output ack0, ack1, done0, done1, out, carry, over, agteqb, busy,
    output alu_x, alu_y, alu_fxn
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// IDLE -> EXEC -> RESP sequence; one operation every three cycles.
module alu_arbiter (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_nxt;
  logic       gnt, ptr, sel;
  logic       grant, capture, finish;
  logic       ack0, ack1, done0, done1;
  logic [5:0] out, alu_x, alu_y;
  logic [2:0] alu_fxn;
  logic       carry, over, agteqb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ptr only breaks ties; a lone request wins regardless of ptr.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    sel       = (bus.req0 && bus.req1) ? ptr : bus.req1;
    case (state)
      IDLE: if (bus.req0 || bus.req1) begin
        grant     = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= 1'b0;
      ptr     <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      alu_x   <= '0;
      alu_y   <= '0;
      alu_fxn <= '0;
      out     <= '0;
      carry   <= 1'b0;
      over    <= 1'b0;
      agteqb  <= 1'b0;
    end else begin
      ack0  <= grant && !sel;
      ack1  <= grant && sel;
      done0 <= capture && !gnt;
      done1 <= capture && gnt;
      if (grant) begin
        gnt     <= sel;
        alu_x   <= sel ? bus.x1   : bus.x0;
        alu_y   <= sel ? bus.y1   : bus.y0;
        alu_fxn <= sel ? bus.fxn1 : bus.fxn0;
      end
      if (capture) begin
        out    <= bus.alu_out;
        carry  <= bus.alu_carry;
        over   <= bus.alu_over;
        agteqb <= bus.alu_agteqb;
      end
      if (finish) ptr <= ~gnt;
    end
  end

  assign bus.ack0    = ack0;
  assign bus.ack1    = ack1;
  assign bus.done0   = done0;
  assign bus.done1   = done1;
  assign bus.out     = out;
  assign bus.carry   = carry;
  assign bus.over    = over;
  assign bus.agteqb  = agteqb;
  assign bus.busy    = (state != IDLE);
  assign bus.alu_x   = alu_x;
  assign bus.alu_y   = alu_y;
  assign bus.alu_fxn = alu_fxn;
endmodule
